color_select_ctrl: RTL and testbench
====================================

Name: color_select_ctrl

Overview:
- Front-end stage that turns the raw board color switches and pushbutton into the clean one-hot color-select lines (Black, Blue, Green, Cyan, Red, Magenta, Yellow, White) consumed by Top_Display.
- Synchronizes and debounces all user inputs and decides the current 3-bit color code.
- Supports manual selection (switches or step button) and an auto-cycle demo mode that steps through all 8 colors at a fixed interval.

Parameters:
- DEB_CYCLES, 500000, consecutive clk cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- CYCLE_TICKS, 840000, clk cycles per color in auto mode; must be ≥ 2.
- CNT_W, 20, width of the debounce and tick counters; must hold max(DEB_CYCLES, CYCLE_TICKS) − 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw  in  8  raw color switches; bit0=Black, 1=Blue, 2=Green, 3=Cyan, 4=Red, 5=Magenta, 6=Yellow, 7=White.
- btn_next  in  1  raw pushbutton; each press steps the color code +1.
- auto_en  in  1  raw mode switch; 1 = auto-cycle.
- Black, Blue, Green, Cyan, Red, Magenta, Yellow, White  out  1 each  registered one-hot decode of color_code, to Top_Display.
- color_code  out  3  current color index.
- color_chg  out  1  one-cycle pulse on the cycle color_code changes.
- conflict  out  1  level: debounced sw holds more than one bit set.

Behaviour:
- Reset (synchronous, highest priority, takes effect at any point, including mid-debounce or mid-cycle):
  - color_code=0, so Black=1 and all other color outputs=0.
  - color_chg=0, conflict=0.
  - All synchronizer, debounced, previous-debounced and counter registers=0.
  - State=MANUAL.
- Synchronizer: 2 flops per raw line (sw[7:0], btn_next, auto_en; 10 lines).
- Debounce, independent per line:
  - Counter clears whenever the sync value equals the debounced value.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES−1 while still differing, the debounced value takes the sync value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles is never accepted.
- Latency:
  - A raw level stable from edge 1 onward updates its debounced value on edge DEB_CYCLES+2.
  - color_code and color_chg update on edge DEB_CYCLES+3.
  - The one-hot outputs update on edge DEB_CYCLES+3 as well; they are registered from the next-code value, with no extra cycle.
- Events, evaluated each cycle from debounced signals:
  - sw_evt: sw_db ≠ sw_db_q (previous cycle).
  - btn_evt: rising edge of btn_db.
- FSM, 2 states:
  - MANUAL: on sw_evt with sw_db one-hot, color_code takes the bit index.
    - On sw_evt with sw_db zero or multi-hot, code holds.
    - On btn_evt with no valid sw_evt in the same cycle, code+1 mod 8 (7→0).
    - If a valid sw_evt and btn_evt occur together, the switch wins.
    - auto_db=1 moves to AUTO with tick counter=0.
  - AUTO: switches are ignored for code selection; conflict still tracks.
    - The tick counter counts 0..CYCLE_TICKS−1. At terminal count, code+1 mod 8 and the counter returns to 0.
    - btn_evt: code+1 and tick counter=0. If a terminal tick and btn_evt coincide, the code increments once only.
    - auto_db=0 moves to MANUAL: counter cleared, code held.
- color_chg=1 for exactly one cycle on each edge where the registered code differs from its previous value. Setting the same code again produces no pulse.
- conflict=1 when popcount(sw_db) ≥ 2, else 0, registered; it follows sw_db with 1 cycle delay.
- Outputs are exactly one-hot at all times, including reset and idle; no cycle ever has 0 or 2+ color outputs high.

Test Plan (bench uses DEB_CYCLES=4, CYCLE_TICKS=10):
- Reset held 3 cycles with sw=8'h10 raw → Black=1, color_code=0, color_chg=0, conflict=0. After release and 7 more cycles → color_code=4, Red=1, one color_chg pulse.
- 2-cycle glitch on sw[2] from idle (sw=0) → color_code unchanged, no color_chg. Then a stable sw=8'h04 → color_code=2 exactly DEB_CYCLES+3 edges after the change.
- sw=8'h81 stable → conflict=1, code held. Then sw=8'h80 → conflict=0, color_code=7, White=1.
- MANUAL, code=7, press btn_next (held ≥ 5 cycles) → color_code=0, Black=1, single color_chg pulse. Holding the button longer produces no further step.
- auto_en=1 from code=0 → code steps 1,2,…,7,0 every 10 cycles with one color_chg per step. A btn press mid-interval steps once and restarts the 10-cycle count.
- In AUTO at code=3, assert reset for 1 cycle → next cycle code=0, state MANUAL (sync auto_en cleared). auto_en re-accepted after DEB_CYCLES+2 edges.

Source files
------------

// File: rtl/color_select_ctrl_if.sv
// Board-side bundle for the color-select front end: raw user inputs
// travelling into the block and the decoded color lines leaving it.
interface color_select_ctrl_if;
  logic [7:0] sw;
  logic       btn_next;
  logic       auto_en;

  logic       Black;
  logic       Blue;
  logic       Green;
  logic       Cyan;
  logic       Red;
  logic       Magenta;
  logic       Yellow;
  logic       White;
  logic [2:0] color_code;
  logic       color_chg;
  logic       conflict;

  // Board / stimulus side: drives raw inputs, observes color lines.
  modport master (
    output sw, btn_next, auto_en,
    input  Black, Blue, Green, Cyan, Red, Magenta, Yellow, White,
    input  color_code, color_chg, conflict
  );

  // Controller side: consumes raw inputs, produces color lines.
  modport slave (
    input  sw, btn_next, auto_en,
    output Black, Blue, Green, Cyan, Red, Magenta, Yellow, White,
    output color_code, color_chg, conflict
  );
endinterface

// File: rtl/color_select_ctrl.sv
// Color-select front end: synchronizes and debounces the color switches,
// step button and auto-mode switch, then chooses the 3-bit color code
// (manual selection or timed auto-cycle) and drives a registered one-hot
// decode of it toward Top_Display.
module color_select_ctrl #(
  parameter int DEB_CYCLES  = 500000,
  parameter int CYCLE_TICKS = 840000,
  parameter int CNT_W       = 20
) (
  input  logic                clk,
  input  logic                reset,
  color_select_ctrl_if.slave  bus
);

  localparam int             NLINES    = 10;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CYCLE_TICKS - 1);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  // Raw lines packed as {auto_en, btn_next, sw[7:0]}.
  logic [NLINES-1:0] raw;
  assign raw = {bus.auto_en, bus.btn_next, bus.sw};

  // ---- Stage p0/p1: two-flop synchronizer --------------------------------
  logic [NLINES-1:0] sync_p0_d, sync_p0_q;
  logic [NLINES-1:0] sync_p1_d, sync_p1_q;

  // ---- Debounce: per-line stability counter and accepted level ----------
  logic [NLINES-1:0] db_d, db_q;
  logic [CNT_W-1:0]  deb_cnt_d [NLINES];
  logic [CNT_W-1:0]  deb_cnt_q [NLINES];

  // ---- Event detection: previous debounced switch/button ----------------
  logic [7:0] sw_db_prev_d, sw_db_prev_q;
  logic       btn_db_prev_d, btn_db_prev_q;

  // ---- Mode FSM and code selection --------------------------------------
  state_t           state_d, state_q;
  logic [2:0]       code_d, code_q;
  logic [CNT_W-1:0] tick_d, tick_q;

  // ---- Output registers -------------------------------------------------
  logic [7:0] onehot_d, onehot_q;
  logic       chg_d, chg_q;
  logic       conflict_d, conflict_q;

  // Debounced views and derived events.
  logic [7:0] sw_db;
  logic       btn_db;
  logic       auto_db;
  logic       sw_evt;
  logic       sw_valid_evt;
  logic       btn_evt;
  logic [2:0] sw_idx;

  assign sw_db   = db_q[7:0];
  assign btn_db  = db_q[8];
  assign auto_db = db_q[9];

  // Synchronizer chain: each raw line passes through two flops.
  always_comb begin
    sync_p0_d = raw;
    sync_p1_d = sync_p0_q;
  end

  // Debounce: accept a new level only after it has differed from the
  // accepted level for DEB_CYCLES consecutive samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NLINES; i++) begin
      deb_cnt_d[i] = '0;
      if (sync_p1_q[i] != db_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          db_d[i] = sync_p1_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event detection on debounced inputs, plus switch-index encode.
  always_comb begin
    sw_db_prev_d  = sw_db;
    btn_db_prev_d = btn_db;
    sw_evt        = (sw_db != sw_db_prev_q);
    sw_valid_evt  = sw_evt && $onehot(sw_db);
    btn_evt       = btn_db && !btn_db_prev_q;
    sw_idx        = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sw_db[i]) sw_idx = 3'(i);
    end
  end

  // Mode FSM: next state, next color code and auto-cycle tick counter.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tick_d  = tick_q;
    case (state_q)
      MANUAL: begin
        tick_d = '0;
        // A valid switch selection takes priority over a step press.
        if (sw_valid_evt) begin
          code_d = sw_idx;
        end else if (btn_evt) begin
          code_d = code_q + 3'd1;
        end
        if (auto_db) state_d = AUTO;
      end
      AUTO: begin
        if (!auto_db) begin
          state_d = MANUAL;
          tick_d  = '0;
        end else if (btn_evt || (tick_q == TICK_LAST)) begin
          // Coincident press and terminal tick still step only once.
          code_d = code_q + 3'd1;
          tick_d = '0;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = MANUAL;
        tick_d  = '0;
      end
    endcase
  end

  // Output decode: one-hot and change pulse come from the next code so
  // they land on the same edge as color_code itself.
  always_comb begin
    onehot_d   = 8'(1) << code_d;
    chg_d      = (code_d != code_q);
    conflict_d = ($countones(sw_db) > 1);
  end

  // Input pipeline registers: synchronizers, debounce state, event history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0_q     <= '0;
      sync_p1_q     <= '0;
      db_q          <= '0;
      sw_db_prev_q  <= '0;
      btn_db_prev_q <= 1'b0;
      for (int i = 0; i < NLINES; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync_p0_q     <= sync_p0_d;
      sync_p1_q     <= sync_p1_d;
      db_q          <= db_d;
      sw_db_prev_q  <= sw_db_prev_d;
      btn_db_prev_q <= btn_db_prev_d;
      for (int i = 0; i < NLINES; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // FSM state, color code and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MANUAL;
      code_q     <= 3'd0;
      tick_q     <= '0;
      onehot_q   <= 8'h01;
      chg_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      tick_q     <= tick_d;
      onehot_q   <= onehot_d;
      chg_q      <= chg_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.Black      = onehot_q[0];
  assign bus.Blue       = onehot_q[1];
  assign bus.Green      = onehot_q[2];
  assign bus.Cyan       = onehot_q[3];
  assign bus.Red        = onehot_q[4];
  assign bus.Magenta    = onehot_q[5];
  assign bus.Yellow     = onehot_q[6];
  assign bus.White      = onehot_q[7];
  assign bus.color_code = code_q;
  assign bus.color_chg  = chg_q;
  assign bus.conflict   = conflict_q;

endmodule

// File: tb/tb_color_select_ctrl.sv
// Directed bench for color_select_ctrl with short debounce / tick periods.
module tb_color_select_ctrl;

  localparam int DEB = 4;
  localparam int CYC = 10;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   chg_cnt = 0;
  int   base;

  color_select_ctrl_if bus ();

  color_select_ctrl #(
    .DEB_CYCLES  (DEB),
    .CYCLE_TICKS (CYC),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] oh;
  assign oh = {bus.White, bus.Yellow, bus.Magenta, bus.Red,
               bus.Cyan, bus.Green, bus.Blue, bus.Black};

  // Tally color_chg pulses, one per high cycle.
  always @(negedge clk) begin
    if (bus.color_chg === 1'b1) chg_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_code(input string tag, input logic [2:0] exp_code);
    logic [7:0] exp_oh;
    exp_oh = 8'h01 << exp_code;
    chk({tag, "_code"},   32'(bus.color_code), 32'(exp_code));
    chk({tag, "_onehot"}, 32'(oh),             32'(exp_oh));
  endtask

  initial begin
    // Reset held 3 cycles with Red switch already up.
    reset        = 1'b1;
    bus.sw       = 8'h10;
    bus.btn_next = 1'b0;
    bus.auto_en  = 1'b0;
    step(3);
    chk_code("rst", 3'd0);
    chk("rst_black", 32'(bus.Black),     32'd1);
    chk("rst_chg",   32'(bus.color_chg), 32'd0);
    chk("rst_conf",  32'(bus.conflict),  32'd0);
    reset = 1'b0;
    step(6);
    chk_code("red_early", 3'd0);
    step(1);
    chk_code("red", 3'd4);
    chk("red_chg", 32'(bus.color_chg), 32'd1);
    step(1);
    chk("red_chg_end", 32'(bus.color_chg), 32'd0);
    chk("red_pulses",  32'(chg_cnt),       32'd1);

    // Switch back to zero holds, then a 2-cycle glitch is rejected.
    base   = chg_cnt;
    bus.sw = 8'h00;
    step(8);
    bus.sw = 8'h04;
    step(2);
    bus.sw = 8'h00;
    step(10);
    chk_code("glitch", 3'd4);
    chk("glitch_pulses", 32'(chg_cnt - base), 32'd0);
    bus.sw = 8'h04;
    step(DEB + 2);
    chk_code("green_early", 3'd4);
    step(1);
    chk_code("green", 3'd2);
    chk("green_chg", 32'(bus.color_chg), 32'd1);
    step(1);

    // Multi-hot switches: conflict, code held; then White alone.
    base   = chg_cnt;
    bus.sw = 8'h81;
    step(DEB + 2);
    chk("conf_early", 32'(bus.conflict), 32'd0);
    step(1);
    chk("conf_set", 32'(bus.conflict), 32'd1);
    chk_code("conf_hold", 3'd2);
    step(3);
    chk_code("conf_hold2", 3'd2);
    bus.sw = 8'h80;
    step(DEB + 3);
    chk("conf_clr", 32'(bus.conflict), 32'd0);
    chk_code("white", 3'd7);
    step(1);
    chk("white_pulses", 32'(chg_cnt - base), 32'd1);

    // Step button from 7 wraps to 0, held press steps once only.
    base         = chg_cnt;
    bus.btn_next = 1'b1;
    step(DEB + 3);
    chk_code("btn_wrap", 3'd0);
    chk("btn_chg", 32'(bus.color_chg), 32'd1);
    step(5);
    chk_code("btn_hold", 3'd0);
    chk("btn_pulses", 32'(chg_cnt - base), 32'd1);
    bus.btn_next = 1'b0;
    bus.sw       = 8'h00;
    step(8);
    chk_code("btn_rel", 3'd0);
    chk("btn_rel_pulses", 32'(chg_cnt - base), 32'd1);

    // Auto mode: one step every CYC cycles after entering AUTO.
    base        = chg_cnt;
    bus.auto_en = 1'b1;
    step(DEB + 2 + CYC);
    chk_code("auto_pre", 3'd0);
    step(1);
    chk_code("auto_1", 3'd1);
    for (int k = 2; k <= 8; k++) begin
      step(CYC);
      chk_code("auto_k", 3'(k % 8));
    end
    step(2);
    chk("auto_pulses", 32'(chg_cnt - base), 32'd8);

    // Mid-interval press steps once and restarts the interval.
    base         = chg_cnt;
    bus.btn_next = 1'b1;
    step(DEB + 2);
    chk_code("abtn_early", 3'd0);
    step(1);
    chk_code("abtn", 3'd1);
    bus.btn_next = 1'b0;
    step(CYC - 1);
    chk_code("abtn_restart", 3'd1);
    step(1);
    chk_code("abtn_next", 3'd2);
    step(CYC);
    chk_code("auto_3", 3'd3);
    chk("abtn_pulses", 32'(chg_cnt - base), 32'd2);

    // One-cycle reset in AUTO: back to Black, MANUAL, auto re-accepted.
    reset = 1'b1;
    step(1);
    chk_code("rst2", 3'd0);
    chk("rst2_chg",  32'(bus.color_chg), 32'd0);
    chk("rst2_conf", 32'(bus.conflict),  32'd0);
    reset = 1'b0;
    step(DEB + 2 + CYC);
    chk_code("rst2_hold", 3'd0);
    step(1);
    chk_code("rst2_auto", 3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
